// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) between the arbiter (master) and the memory slave.
interface axi_rd_arbiter_if;
   logic [3:0]  m_axi_arid;
   logic [29:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
      output m_axi_arvalid, m_axi_rready,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
      input  m_axi_arvalid, m_axi_rready,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester round-robin AXI4 read arbiter; one burst outstanding, data shared on rd_data.
module axi_rd_arbiter (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       rd_req,
   input  logic [29:0]      rd_addr0,
   input  logic [29:0]      rd_addr1,
   input  logic [7:0]       rd_len0,
   input  logic [7:0]       rd_len1,
   output logic [1:0]       rd_grant,
   output logic [1:0]       rd_dvalid,
   output logic [63:0]      rd_data,
   output logic             rd_last,
   output logic [1:0]       rd_done,
   axi_rd_arbiter_if.master axi
);

   typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

   state_e      state_q, state_d;
   logic        arvalid_q, arvalid_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  done_q, done_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [29:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;

   logic        sel;
   logic        in_r;
   logic        r_hs;
   logic        term;

   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign sel  = rd_req[1] & ~(rd_req[0] & last_owner_q);
   assign in_r = (state_q == StR);
   assign r_hs = axi.m_axi_rvalid & in_r;
   assign term = r_hs & (axi.m_axi_rlast | (cnt_q == len_q));

   always_comb begin
      state_d      = state_q;
      arvalid_d    = arvalid_q;
      grant_d      = 2'b00;
      done_d       = 2'b00;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      len_d        = len_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      unique case (state_q)
         StIdle: begin
            // Hold off while rd_done is pulsing so grant and done never coincide.
            if ((rd_req != 2'b00) && (done_q == 2'b00)) begin
               state_d      = StAr;
               arvalid_d    = 1'b1;
               grant_d      = sel ? 2'b10 : 2'b01;
               owner_d      = sel;
               last_owner_d = sel;
               addr_d       = sel ? rd_addr1 : rd_addr0;
               len_d        = sel ? rd_len1 : rd_len0;
            end
         end
         StAr: begin
            cnt_d = 8'd0;
            if (arvalid_q && axi.m_axi_arready) begin
               state_d   = StR;
               arvalid_d = 1'b0;
            end
         end
         StR: begin
            if (r_hs) begin
               cnt_d = cnt_q + 8'd1;
            end
            if (term) begin
               state_d = StIdle;
               done_d  = owner_q ? 2'b10 : 2'b01;
            end
         end
         default: begin
            state_d   = StIdle;
            arvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         arvalid_q    <= 1'b0;
         grant_q      <= 2'b00;
         done_q       <= 2'b00;
         cnt_q        <= 8'd0;
         addr_q       <= 30'd0;
         len_q        <= 8'd0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         arvalid_q    <= arvalid_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   assign rd_grant  = grant_q;
   assign rd_done   = done_q;
   assign rd_data   = axi.m_axi_rdata;
   assign rd_dvalid = {owner_q & r_hs, ~owner_q & r_hs};
   assign rd_last   = r_hs & axi.m_axi_rlast;

   assign axi.m_axi_arid    = {3'b000, owner_q};
   assign axi.m_axi_araddr  = addr_q;
   assign axi.m_axi_arlen   = len_q;
   assign axi.m_axi_arsize  = 3'b011;
   assign axi.m_axi_arburst = 2'b01;
   assign axi.m_axi_arvalid = arvalid_q;
   assign axi.m_axi_rready  = in_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed bursts, expectations queued, monitor compares.
module tb_axi_rd_arbiter;

   typedef struct {
      logic [29:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      int          stall;
   } ar_t;

   typedef struct {
      logic [1:0]  oh;
      logic [63:0] data;
      logic        last;
      logic        term;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rd_req;
   logic [29:0] rd_addr0, rd_addr1;
   logic [7:0]  rd_len0, rd_len1;
   logic [1:0]  rd_grant, rd_dvalid, rd_done;
   logic [63:0] rd_data;
   logic        rd_last;

   axi_rd_arbiter_if axi ();

   axi_rd_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_req    (rd_req),
      .rd_addr0  (rd_addr0),
      .rd_addr1  (rd_addr1),
      .rd_len0   (rd_len0),
      .rd_len1   (rd_len1),
      .rd_grant  (rd_grant),
      .rd_dvalid (rd_dvalid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .rd_done   (rd_done),
      .axi       (axi)
   );

   always #5 clk = ~clk;

   logic [1:0] exp_grant[$];
   logic [1:0] exp_done[$];
   ar_t        exp_ar[$];
   beat_t      exp_beat[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Slave behaviour knobs, set by the stimulus between bursts.
   int cfg_stall  = 0;
   bit cfg_toggle = 1'b0;
   int cfg_rlast  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_burst(input logic owner, input logic [29:0] addr, input logic [7:0] len,
                             input int stall, input int nb, input int rlast_idx,
                             input bit with_done);
      logic [1:0] oh;
      ar_t        a;
      beat_t      b;
      oh = owner ? 2'b10 : 2'b01;
      exp_grant.push_back(oh);
      a.addr  = addr;
      a.len   = len;
      a.id    = {3'b000, owner};
      a.stall = stall;
      exp_ar.push_back(a);
      for (int i = 0; i < nb; i++) begin
         b.oh   = oh;
         b.data = {26'd0, addr, 8'(i)};
         b.last = (i == rlast_idx);
         b.term = with_done && (i == nb - 1);
         exp_beat.push_back(b);
      end
      if (with_done) exp_done.push_back(oh);
   endtask

   // what: 0 = grants, 1 = beats, 2 = everything
   function automatic int pending(input int what);
      if (what == 0) return exp_grant.size();
      if (what == 1) return exp_beat.size();
      return exp_grant.size() + exp_beat.size() + exp_ar.size() + exp_done.size();
   endfunction

   task automatic wait_drained(input string name, input int what, input int budget);
      int n;
      n = 0;
      @(negedge clk); #1;
      while (pending(what) != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (pending(what) != 0) chk(name, 64'(pending(what)), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_grant"},   64'(rd_grant), 64'd0);
      chk({tag, "_done"},    64'(rd_done), 64'd0);
      chk({tag, "_dvalid"},  64'(rd_dvalid), 64'd0);
      chk({tag, "_last"},    64'(rd_last), 64'd0);
      chk({tag, "_arvalid"}, 64'(axi.m_axi_arvalid), 64'd0);
      chk({tag, "_rready"},  64'(axi.m_axi_rready), 64'd0);
      chk({tag, "_araddr"},  64'(axi.m_axi_araddr), 64'd0);
      chk({tag, "_arlen"},   64'(axi.m_axi_arlen), 64'd0);
      chk({tag, "_arid"},    64'(axi.m_axi_arid), 64'd0);
   endtask

   // Slave: AR stall, optional rvalid toggling, rlast at a chosen beat; data = {addr, beat}.
   initial begin : slave
      int          beat, ar_wait;
      bit          in_burst, tog, ar_hs, r_hs, last_seen, done_seen, rst_seen;
      logic [29:0] sl_addr, addr_cap;
      beat = 0; ar_wait = 0; in_burst = 0; tog = 0; sl_addr = '0;
      axi.m_axi_arready = 1'b0;
      axi.m_axi_rvalid  = 1'b0;
      axi.m_axi_rlast   = 1'b0;
      axi.m_axi_rdata   = '0;
      axi.m_axi_rresp   = 2'b00;
      forever begin
         @(negedge clk);
         rst_seen  = !rst_n;
         ar_hs     = axi.m_axi_arvalid & axi.m_axi_arready;
         r_hs      = axi.m_axi_rvalid & axi.m_axi_rready;
         last_seen = axi.m_axi_rlast;
         done_seen = |rd_done;
         addr_cap  = axi.m_axi_araddr;
         @(posedge clk); #1;
         if (rst_seen) begin
            in_burst = 0;
            beat     = 0;
         end else begin
            if (ar_hs) begin
               in_burst = 1;
               beat     = 0;
               sl_addr  = addr_cap;
            end else if (r_hs) begin
               beat++;
               if (last_seen) in_burst = 0;
            end
            if (done_seen) in_burst = 0;
         end
         if (axi.m_axi_arvalid) begin
            if (ar_wait >= cfg_stall) axi.m_axi_arready = 1'b1;
            else begin
               axi.m_axi_arready = 1'b0;
               ar_wait++;
            end
         end else begin
            axi.m_axi_arready = 1'b0;
            ar_wait = 0;
         end
         tog = ~tog;
         axi.m_axi_rvalid = in_burst & (!cfg_toggle | tog);
         axi.m_axi_rlast  = axi.m_axi_rvalid & (beat == cfg_rlast);
         axi.m_axi_rdata  = {26'd0, sl_addr, 8'(beat)};
         axi.m_axi_rresp  = 2'b10;
      end
   end

   // Monitor: pops scoreboard entries whenever the DUT presents an event.
   initial begin : monitor
      int    cyc, term_cyc, ar_cyc;
      ar_t   a;
      beat_t b;
      cyc = 0; term_cyc = -100; ar_cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rd_grant != 2'b00) begin
            if (exp_grant.size() == 0) chk("grant_unexpected", 64'(rd_grant), 64'd0);
            else chk("grant", 64'(rd_grant), 64'(exp_grant.pop_front()));
         end
         if (axi.m_axi_arvalid) begin
            ar_cyc++;
            if (exp_ar.size() == 0) chk("ar_unexpected", 64'(axi.m_axi_arvalid), 64'd0);
            else begin
               a = exp_ar[0];
               chk("araddr", 64'(axi.m_axi_araddr), 64'(a.addr));
               chk("arlen", 64'(axi.m_axi_arlen), 64'(a.len));
               chk("arid", 64'(axi.m_axi_arid), 64'(a.id));
               chk("arsize_arburst", 64'({axi.m_axi_arsize, axi.m_axi_arburst}), 64'h0D);
               if (axi.m_axi_arready) begin
                  chk("arvalid_hold_cycles", 64'(ar_cyc), 64'(a.stall + 1));
                  void'(exp_ar.pop_front());
                  ar_cyc = 0;
               end
            end
         end else begin
            ar_cyc = 0;
         end
         if (rd_dvalid != 2'b00) begin
            if (exp_beat.size() == 0) chk("beat_unexpected", 64'(rd_dvalid), 64'd0);
            else begin
               b = exp_beat.pop_front();
               chk("dvalid", 64'(rd_dvalid), 64'(b.oh));
               chk("rd_data", rd_data, b.data);
               chk("rd_last", 64'(rd_last), 64'(b.last));
               if (b.term) term_cyc = cyc;
            end
         end
         if (axi.m_axi_rvalid && !axi.m_axi_rready) begin
            chk("stray_rvalid_dvalid", 64'(rd_dvalid), 64'd0);
         end
         if (rd_done != 2'b00) begin
            chk("grant_with_done", 64'(rd_grant), 64'd0);
            if (exp_done.size() == 0) chk("done_unexpected", 64'(rd_done), 64'd0);
            else begin
               chk("done", 64'(rd_done), 64'(exp_done.pop_front()));
               chk("done_latency", 64'(cyc - term_cyc), 64'd1);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n = 1'b0; rd_req = 2'b00;
      rd_addr0 = '0; rd_addr1 = '0; rd_len0 = '0; rd_len1 = '0;
      @(negedge clk);
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single request from requester 0, rlast on beat 4.
      cfg_stall = 0; cfg_toggle = 0; cfg_rlast = 3;
      rd_addr0 = 30'h100; rd_len0 = 8'd3;
      push_burst(1'b0, 30'h100, 8'd3, 0, 4, 3, 1'b1);
      rd_req = 2'b01;
      wait_drained("timeout_t1_grant", 0, 20);
      rd_req = 2'b00;
      wait_drained("timeout_t1_burst", 2, 40);

      // Single request from requester 1, leaves last_owner = 1.
      cfg_rlast = 0;
      rd_addr1 = 30'h180; rd_len1 = 8'd0;
      push_burst(1'b1, 30'h180, 8'd0, 0, 1, 0, 1'b1);
      rd_req = 2'b10;
      wait_drained("timeout_t2_grant", 0, 20);
      rd_req = 2'b00;
      wait_drained("timeout_t2_burst", 2, 40);

      // Tie held across three bursts: 01, 10, 01.
      cfg_rlast = 1;
      rd_addr0 = 30'h200; rd_len0 = 8'd1;
      rd_addr1 = 30'h2A0; rd_len1 = 8'd1;
      push_burst(1'b0, 30'h200, 8'd1, 0, 2, 1, 1'b1);
      push_burst(1'b1, 30'h2A0, 8'd1, 0, 2, 1, 1'b1);
      push_burst(1'b0, 30'h200, 8'd1, 0, 2, 1, 1'b1);
      rd_req = 2'b11;
      wait_drained("timeout_tie_grant", 0, 60);
      rd_req = 2'b00;
      wait_drained("timeout_tie_burst", 2, 40);

      // AR backpressure 5 cycles, toggling rvalid, no rlast: ends on beat count.
      cfg_stall = 5; cfg_toggle = 1; cfg_rlast = -1;
      rd_addr1 = 30'h3C0; rd_len1 = 8'd3;
      push_burst(1'b1, 30'h3C0, 8'd3, 5, 4, -1, 1'b1);
      rd_req = 2'b10;
      wait_drained("timeout_bp_grant", 0, 20);
      rd_req = 2'b00;
      wait_drained("timeout_bp_burst", 2, 60);
      cfg_stall = 0; cfg_toggle = 0;

      // Early rlast on beat 2 of an 8-beat request.
      cfg_rlast = 1;
      rd_addr0 = 30'h0AB; rd_len0 = 8'd7;
      push_burst(1'b0, 30'h0AB, 8'd7, 0, 2, 1, 1'b1);
      rd_req = 2'b01;
      wait_drained("timeout_er_grant", 0, 20);
      rd_req = 2'b00;
      wait_drained("timeout_er_burst", 2, 40);

      // Reset while beat 2 of a 4-beat burst is on the bus: no rd_done.
      cfg_rlast = 3;
      rd_addr0 = 30'h300; rd_len0 = 8'd3;
      push_burst(1'b0, 30'h300, 8'd3, 0, 1, 3, 1'b0);
      rd_req = 2'b01;
      wait_drained("timeout_rst_grant", 0, 20);
      rd_req = 2'b00;
      wait_drained("timeout_rst_beat", 1, 20);
      rst_n  = 1'b0;
      rd_req = 2'b11;
      @(negedge clk);
      check_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      check_reset_outputs("midrst_hold");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // First tie after reset goes to requester 0.
      cfg_rlast = 0;
      rd_addr0 = 30'h400; rd_len0 = 8'd0;
      push_burst(1'b0, 30'h400, 8'd0, 0, 1, 0, 1'b1);
      wait_drained("timeout_post_grant", 0, 20);
      rd_req = 2'b00;
      wait_drained("timeout_post_burst", 2, 40);

      repeat (5) @(posedge clk);
      #1;
      chk("sb_grant_empty", 64'(exp_grant.size()), 64'd0);
      chk("sb_ar_empty",    64'(exp_ar.size()), 64'd0);
      chk("sb_beat_empty",  64'(exp_beat.size()), 64'd0);
      chk("sb_done_empty",  64'(exp_done.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have no parameters; AXI ID width 4, address 30, data 64, length 8 bits are fixed.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rd_req  in  2  per-requester read request, level, held until granted.
REQ-005 rd_addr0  in  30  requester 0 burst start address.
REQ-006 rd_addr1  in  30  requester 1 burst start address.
REQ-007 rd_len0  in  8  requester 0 burst length minus 1.
REQ-008 rd_len1  in  8  requester 1 burst length minus 1.
REQ-009 rd_grant  out  2  one-cycle, one-hot grant pulse.
REQ-010 rd_dvalid  out  2  per-requester read-data valid, one-hot or zero.
REQ-011 rd_data  out  64  read data, shared by both requesters.
REQ-012 rd_last  out  1  final beat of the current burst.
REQ-013 rd_done  out  2  one-cycle burst-complete pulse per requester.
REQ-014 m_axi_arid  out  4  {3'b000, owner}.
REQ-015 m_axi_araddr  out  30  latched address.
REQ-016 m_axi_arlen  out  8  latched length.
REQ-017 m_axi_arsize  out  3  constant 3'b011 (8 bytes).
REQ-018 m_axi_arburst  out  2  constant 2'b01 (INCR).
REQ-019 m_axi_arvalid  out  1  read-address valid.
REQ-020 m_axi_arready  in  1  slave address ready.
REQ-021 m_axi_rdata  in  64  slave read data.
REQ-022 m_axi_rresp  in  2  read response; ignored.
REQ-023 m_axi_rlast  in  1  slave last beat.
REQ-024 m_axi_rvalid  in  1  slave data valid.
REQ-025 m_axi_rready  out  1  master data ready.

Function
REQ-026 State machine SHALL have states IDLE, AR and R; exactly one burst is outstanding at a time.
REQ-027 In IDLE, when rd_req != 0, the block SHALL select an owner, pulse rd_grant[owner] for one cycle, latch that requester's address and length, and move to AR on the next edge.
REQ-028 Arbitration SHALL be round-robin: if only one request is active, that requester wins; if both are active, the requester other than last_owner wins.
REQ-029 last_owner SHALL update at grant and SHALL reset to 1, so requester 0 wins the first tie.
REQ-030 In AR, m_axi_arvalid SHALL be 1 and m_axi_araddr/arlen/arid SHALL be stable until m_axi_arvalid & m_axi_arready; the block SHALL then go to R.
REQ-031 m_axi_arvalid SHALL be registered, asserted on the IDLE->AR transition, and deasserted on the handshake cycle edge.
REQ-032 In R, m_axi_rready SHALL be 1; in all other states it SHALL be 0.
REQ-033 rd_data SHALL equal m_axi_rdata combinationally.
REQ-034 rd_dvalid[owner] SHALL equal m_axi_rvalid & (state==R).
REQ-035 rd_last SHALL equal m_axi_rvalid & m_axi_rlast & (state==R).
REQ-036 An 8-bit beat counter SHALL clear in AR and increment on each R-state handshake.
REQ-037 The burst SHALL terminate on the handshake with m_axi_rlast=1, or on the handshake where the counter equals the latched length, whichever comes first.
REQ-038 On termination the block SHALL pulse rd_done[owner] on the following cycle and return to IDLE.
REQ-039 A new grant SHALL NOT be issued in the same cycle as rd_done.
REQ-040 A requester deasserting rd_req after its grant SHALL NOT affect the burst in progress.
REQ-041 rvalid arriving outside R SHALL be ignored: rready stays 0 and no dvalid is produced.

Reset
REQ-042 While rst_n=0, the block SHALL force: state IDLE; m_axi_arvalid 0; rd_grant 0; rd_done 0; counter 0; latched address, length and owner 0; last_owner 1.
REQ-043 Reset mid-burst SHALL abandon the burst with no rd_done pulse; the first grant after reset SHALL follow REQ-028 and REQ-029.

Verification
REQ-044 Single request: rd_req=01, addr0=0x100, len0=3, arready=1, rvalid=1 -> grant=01, araddr=0x100, arlen=3, arid=0, 4 dvalid[0] beats, rd_last on beat 4, rd_done=01 one cycle later.
REQ-045 Tie: rd_req=11 held through three bursts -> grants issued 01, 10, 01 in that order.
REQ-046 Backpressure: arready low for 5 cycles -> arvalid held high with araddr/arlen stable; rvalid toggling -> beats counted only on handshake cycles.
REQ-047 Early rlast: len=7 with slave rlast on beat 2 -> burst ends after 2 beats and rd_done pulses once.
REQ-048 Reset during beat 2 of a len=3 burst -> all outputs return to reset values, no rd_done; after release, rd_req=11 -> grant=01.
